// File: rtl/vending_machine_param_if.sv
// Purpose: handshake and status bundle between a vending machine and its environment.
// Ports: coin/cancel/chg_rdy flow into the machine; sell, change/chg_vld, coin_rdy,
//        empty, credit and stock flow out. slave = machine side, master = environment side.
interface vending_machine_param_if;
  logic [1:0] coin;
  logic       cancel;
  logic       chg_rdy;
  logic       sell;
  logic [1:0] change;
  logic       chg_vld;
  logic       coin_rdy;
  logic       empty;
  logic [4:0] credit;
  logic [7:0] stock;

  modport slave (
    input  coin, cancel, chg_rdy,
    output sell, change, chg_vld, coin_rdy, empty, credit, stock
  );

  modport master (
    output coin, cancel, chg_rdy,
    input  sell, change, chg_vld, coin_rdy, empty, credit, stock
  );
endinterface

// File: rtl/vending_machine_param.sv
// Purpose: single-item vending machine. It collects coins, vends one item when the
//          credit reaches PRICE, and returns change as coin beats on a valid/ready tray.
// Latency: sell pulses the cycle after the completing coin. The first change beat
//          follows the sell cycle, or the cycle after a sampled cancel.
// Backpressure: change/chg_vld hold while chg_rdy=0. Coins are refused (coin_rdy=0)
//          outside IDLE/COLLECT and once stock is exhausted.
// Ports: clk, rstn (async active-low), bus (vending_machine_param_if.slave).
module vending_machine_param #(
  parameter int PRICE      = 4,  // 1..15, in 0.5-units
  parameter int STOCK_INIT = 8   // 0..255
) (
  input  logic                           clk,
  input  logic                           rstn,
  vending_machine_param_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    REFUND  = 2'd3
  } state_t;

  localparam logic [4:0] PRICE_U    = 5'(PRICE);
  localparam logic [7:0] STOCK_INIT_U = 8'(STOCK_INIT);

  state_t     state, nxt_state;
  logic [4:0] credit, nxt_credit;
  logic [7:0] stock, nxt_stock;

  logic       accept;
  logic [4:0] coin_val;
  logic [4:0] sum;
  logic [1:0] chg_code;
  logic [4:0] chg_val;

  // Change is paid greedily, largest coin first. The code depends only on the
  // credit register, so it stays stable while the tray stalls.
  always_comb begin
    chg_code = 2'b01;
    chg_val  = 5'd1;
    if (credit >= 5'd4) begin
      chg_code = 2'b11;
      chg_val  = 5'd4;
    end else if (credit >= 5'd2) begin
      chg_code = 2'b10;
      chg_val  = 5'd2;
    end
  end

  always_comb begin
    coin_val = 5'd0;
    case (bus.coin)
      2'b01:   coin_val = 5'd1;
      2'b10:   coin_val = 5'd2;
      2'b11:   coin_val = 5'd4;
      default: coin_val = 5'd0;
    endcase
  end

  assign accept = ((state == IDLE) || (state == COLLECT)) && (stock != 8'd0);
  // Credit stays below PRICE while collecting, so the sum is at most 18.
  assign sum    = credit + coin_val;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      credit <= 5'd0;
      stock  <= STOCK_INIT_U;
    end else begin
      state  <= nxt_state;
      credit <= nxt_credit;
      stock  <= nxt_stock;
    end
  end

  // Next-state logic
  always_comb begin
    nxt_state  = state;
    nxt_credit = credit;
    nxt_stock  = stock;
    case (state)
      IDLE, COLLECT: begin
        if (accept) begin
          if (bus.coin != 2'b00) begin
            // The coin counts before cancel, so a completing coin wins over a refund.
            if (sum >= PRICE_U) begin
              nxt_state  = VEND;
              nxt_credit = sum - PRICE_U;
              nxt_stock  = stock - 8'd1;
            end else if (bus.cancel) begin
              nxt_state  = REFUND;
              nxt_credit = sum;
            end else begin
              nxt_state  = COLLECT;
              nxt_credit = sum;
            end
          end else if (bus.cancel && (state == COLLECT)) begin
            nxt_state = REFUND;
          end
        end
      end
      VEND: begin
        nxt_state = (credit != 5'd0) ? REFUND : IDLE;
      end
      REFUND: begin
        if (bus.chg_rdy) begin
          nxt_credit = credit - chg_val;
          if (credit == chg_val) begin
            nxt_state = IDLE;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.sell     = (state == VEND);
    bus.chg_vld  = (state == REFUND);
    bus.change   = (state == REFUND) ? chg_code : 2'b00;
    bus.coin_rdy = accept;
    bus.empty    = (stock == 8'd0);
    bus.credit   = credit;
    bus.stock    = stock;
  end

endmodule

// File: tb/tb_vending_machine_param.sv
module tb_vending_machine_param;

  logic clk;
  logic rstn_a;
  logic rstn_b;

  vending_machine_param_if ia ();
  vending_machine_param_if ib ();

  // A: default price/stock. B: dear item (so a 2.0 change beat is reachable) and one in stock.
  vending_machine_param #(.PRICE(4), .STOCK_INIT(8)) dut_a (
    .clk  (clk),
    .rstn (rstn_a),
    .bus  (ia)
  );

  vending_machine_param #(.PRICE(9), .STOCK_INIT(1)) dut_b (
    .clk  (clk),
    .rstn (rstn_b),
    .bus  (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required a finished test");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] coin;
    logic       cancel;
    logic       chg_rdy;
    logic       sell;
    logic       chg_vld;
    logic [1:0] change;
    logic       coin_rdy;
    logic       empty;
    logic [4:0] credit;
    logic [7:0] stock;
  } vec_t;

  // {sell, chg_vld, change, coin_rdy, empty, credit, stock}
  typedef logic [18:0] obs_t;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  vec_t va[$];
  vec_t vb[$];

  function automatic vec_t v(input logic [1:0] coin, input logic cancel, input logic chg_rdy,
                             input logic sell, input logic chg_vld, input logic [1:0] change,
                             input logic coin_rdy, input logic empty,
                             input logic [4:0] credit, input logic [7:0] stock);
    vec_t r;
    r.coin = coin; r.cancel = cancel; r.chg_rdy = chg_rdy;
    r.sell = sell; r.chg_vld = chg_vld; r.change = change;
    r.coin_rdy = coin_rdy; r.empty = empty; r.credit = credit; r.stock = stock;
    return r;
  endfunction

  function automatic obs_t exp_of(input vec_t t);
    return {t.sell, t.chg_vld, t.change, t.coin_rdy, t.empty, t.credit, t.stock};
  endfunction

  function automatic obs_t observe(input bit sel);
    if (sel)
      return {ib.sell, ib.chg_vld, ib.change, ib.coin_rdy, ib.empty, ib.credit, ib.stock};
    else
      return {ia.sell, ia.chg_vld, ia.change, ia.coin_rdy, ia.empty, ia.credit, ia.stock};
  endfunction

  task automatic drive(input bit sel, input logic [1:0] coin, input logic cancel,
                       input logic chg_rdy);
    if (sel) begin
      ib.coin = coin; ib.cancel = cancel; ib.chg_rdy = chg_rdy;
    end else begin
      ia.coin = coin; ia.cancel = cancel; ia.chg_rdy = chg_rdy;
    end
  endtask

  task automatic compare(input bit sel, input string name);
    obs_t got;
    obs_t want;
    got  = observe(sel);
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got sell=%b vld=%b chg=%b rdy=%b empty=%b credit=%0d stock=%0d, required sell=%b vld=%b chg=%b rdy=%b empty=%b credit=%0d stock=%0d",
               name, got[18], got[17], got[16:15], got[14], got[13], got[12:8], got[7:0],
               want[18], want[17], want[16:15], want[14], want[13], want[12:8], want[7:0]);
    end
  endtask

  // Drive one vector, queue its expectation, and check it just after the edge.
  task automatic apply(input bit sel, input vec_t t, input string name);
    drive(sel, t.coin, t.cancel, t.chg_rdy);
    exp_q.push_back(exp_of(t));
    @(posedge clk);
    #1;
    compare(sel, name);
  endtask

  initial begin
    //               coin   cx  rdy  sell vld chg   crdy emp cr  st
    // Four half-units in a row: exact price, no change.
    va.push_back(v(2'b01, 0, 0,   0, 0, 2'b00, 1, 0, 1, 8));
    va.push_back(v(2'b01, 0, 0,   0, 0, 2'b00, 1, 0, 2, 8));
    va.push_back(v(2'b01, 0, 0,   0, 0, 2'b00, 1, 0, 3, 8));
    va.push_back(v(2'b01, 0, 0,   1, 0, 2'b00, 0, 0, 0, 7));
    va.push_back(v(2'b00, 0, 0,   0, 0, 2'b00, 1, 0, 0, 7));
    // 1.0 + 0.5 + 1.0: one unit back as a single 0.5 beat.
    va.push_back(v(2'b10, 0, 1,   0, 0, 2'b00, 1, 0, 2, 7));
    va.push_back(v(2'b01, 0, 1,   0, 0, 2'b00, 1, 0, 3, 7));
    va.push_back(v(2'b10, 0, 1,   1, 0, 2'b00, 0, 0, 1, 6));
    va.push_back(v(2'b00, 0, 1,   0, 1, 2'b01, 0, 0, 1, 6));
    va.push_back(v(2'b00, 0, 1,   0, 0, 2'b00, 1, 0, 0, 6));
    // A 2.0 coin alone pays; the second one arrives during VEND and is refused.
    va.push_back(v(2'b11, 0, 0,   1, 0, 2'b00, 0, 0, 0, 5));
    va.push_back(v(2'b11, 0, 0,   0, 0, 2'b00, 1, 0, 0, 5));
    // Remainder 3 with a stalled tray: 1.0 beat held, then 0.5 beat held.
    va.push_back(v(2'b10, 0, 0,   0, 0, 2'b00, 1, 0, 2, 5));
    va.push_back(v(2'b01, 0, 0,   0, 0, 2'b00, 1, 0, 3, 5));
    va.push_back(v(2'b11, 0, 0,   1, 0, 2'b00, 0, 0, 3, 4));
    va.push_back(v(2'b00, 0, 0,   0, 1, 2'b10, 0, 0, 3, 4));
    va.push_back(v(2'b01, 0, 0,   0, 1, 2'b10, 0, 0, 3, 4));
    va.push_back(v(2'b00, 1, 0,   0, 1, 2'b10, 0, 0, 3, 4));
    va.push_back(v(2'b00, 0, 1,   0, 1, 2'b01, 0, 0, 1, 4));
    va.push_back(v(2'b00, 0, 0,   0, 1, 2'b01, 0, 0, 1, 4));
    va.push_back(v(2'b00, 0, 1,   0, 0, 2'b00, 1, 0, 0, 4));
    // 0.5 + 1.0 then cancel: beats 1.0 then 0.5, no sale.
    va.push_back(v(2'b01, 0, 0,   0, 0, 2'b00, 1, 0, 1, 4));
    va.push_back(v(2'b10, 0, 0,   0, 0, 2'b00, 1, 0, 3, 4));
    va.push_back(v(2'b00, 1, 0,   0, 1, 2'b10, 0, 0, 3, 4));
    va.push_back(v(2'b00, 0, 1,   0, 1, 2'b01, 0, 0, 1, 4));
    va.push_back(v(2'b00, 0, 1,   0, 0, 2'b00, 1, 0, 0, 4));
    // Cancel with no credit is ignored.
    va.push_back(v(2'b00, 1, 0,   0, 0, 2'b00, 1, 0, 0, 4));
    // Coin plus cancel: completing coin sells.
    va.push_back(v(2'b01, 0, 0,   0, 0, 2'b00, 1, 0, 1, 4));
    va.push_back(v(2'b11, 1, 0,   1, 0, 2'b00, 0, 0, 1, 3));
    va.push_back(v(2'b00, 0, 1,   0, 1, 2'b01, 0, 0, 1, 3));
    va.push_back(v(2'b00, 0, 1,   0, 0, 2'b00, 1, 0, 0, 3));
    // Coin plus cancel below price from IDLE: whole sum refunded.
    va.push_back(v(2'b01, 1, 0,   0, 1, 2'b01, 0, 0, 1, 3));
    va.push_back(v(2'b00, 0, 1,   0, 0, 2'b00, 1, 0, 0, 3));
    // Build a refund of 3 for the reset-during-refund case.
    va.push_back(v(2'b01, 0, 0,   0, 0, 2'b00, 1, 0, 1, 3));
    va.push_back(v(2'b10, 0, 0,   0, 0, 2'b00, 1, 0, 3, 3));
    va.push_back(v(2'b00, 1, 0,   0, 1, 2'b10, 0, 0, 3, 3));

    // B: PRICE=9, STOCK_INIT=1
    // 2.0 then cancel: 2.0 beat held three stalled cycles.
    vb.push_back(v(2'b11, 0, 0,   0, 0, 2'b00, 1, 0, 4, 1));
    vb.push_back(v(2'b00, 1, 0,   0, 1, 2'b11, 0, 0, 4, 1));
    vb.push_back(v(2'b00, 0, 0,   0, 1, 2'b11, 0, 0, 4, 1));
    vb.push_back(v(2'b00, 0, 0,   0, 1, 2'b11, 0, 0, 4, 1));
    vb.push_back(v(2'b00, 0, 0,   0, 1, 2'b11, 0, 0, 4, 1));
    vb.push_back(v(2'b00, 0, 1,   0, 0, 2'b00, 1, 0, 0, 1));
    // Last item: 4+4+2=10, remainder 1 still refunded, then sold out.
    vb.push_back(v(2'b11, 0, 0,   0, 0, 2'b00, 1, 0, 4, 1));
    vb.push_back(v(2'b11, 0, 0,   0, 0, 2'b00, 1, 0, 8, 1));
    vb.push_back(v(2'b10, 0, 0,   1, 0, 2'b00, 0, 1, 1, 0));
    vb.push_back(v(2'b00, 0, 1,   0, 1, 2'b01, 0, 1, 1, 0));
    vb.push_back(v(2'b00, 0, 1,   0, 0, 2'b00, 0, 1, 0, 0));
    vb.push_back(v(2'b10, 0, 0,   0, 0, 2'b00, 0, 1, 0, 0));
    vb.push_back(v(2'b01, 1, 0,   0, 0, 2'b00, 0, 1, 0, 0));
    vb.push_back(v(2'b00, 0, 0,   0, 0, 2'b00, 0, 1, 0, 0));

    drive(0, 2'b00, 0, 0);
    drive(1, 2'b00, 0, 0);
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(exp_of(v(2'b00, 0, 0, 0, 0, 2'b00, 1, 0, 0, 8)));
    compare(0, "reset_a");
    exp_q.push_back(exp_of(v(2'b00, 0, 0, 0, 0, 2'b00, 1, 0, 0, 1)));
    compare(1, "reset_b");
    @(negedge clk);
    rstn_a = 1'b1;
    rstn_b = 1'b1;

    foreach (va[i]) apply(0, va[i], $sformatf("a_vec%0d", i));

    // Reset asserted mid-REFUND (credit 3): outputs clear without waiting for an edge.
    #2;
    rstn_a = 1'b0;
    #1;
    exp_q.push_back(exp_of(v(2'b00, 0, 0, 0, 0, 2'b00, 1, 0, 0, 8)));
    compare(0, "async_reset_refund");
    @(negedge clk);
    rstn_a = 1'b1;
    // No leftover beat after release, and the first coin is taken at once.
    apply(0, v(2'b00, 0, 1, 0, 0, 2'b00, 1, 0, 0, 8), "after_reset_idle");
    apply(0, v(2'b10, 0, 1, 0, 0, 2'b00, 1, 0, 2, 8), "after_reset_coin");

    // Reset during COLLECT discards credit as well.
    #2;
    rstn_a = 1'b0;
    #1;
    exp_q.push_back(exp_of(v(2'b00, 0, 0, 0, 0, 2'b00, 1, 0, 0, 8)));
    compare(0, "async_reset_collect");
    @(negedge clk);
    rstn_a = 1'b1;
    apply(0, v(2'b01, 0, 0, 0, 0, 2'b00, 1, 0, 1, 8), "collect_reset_coin");

    foreach (vb[i]) apply(1, vb[i], $sformatf("b_vec%0d", i));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
